invader_bolts: RTL and testbench
================================

# invader_bolts

Pool of up to BOLT_MAX invader bolts (enemy shots) feeding the btiRGB/btiReq input of the object priority mux. It accepts fire requests from the invader matrix, allocates bolts to free slots, moves them down once per frame, and retires them at the screen bottom or on collision. For each VGA pixel it produces a registered draw request and colour.

## Interface
- BOLT_MAX, 4: number of bolt slots (1..8).
- BOLT_W, 4: bolt width in pixels.
- BOLT_H, 12: bolt height in pixels.
- SPEED, 4: downward pixels per frame.
- SCREEN_BOTTOM, 479: last visible row.
- COOLDOWN, 32: frames between accepted shots.
- BOLT_COLOR, 8'hFC: RGB332 colour (yellow).

- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse, once per frame.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- fireReq  in  1  one-cycle shot request.
- fireX  in  11  bolt top-left column for fireReq.
- fireY  in  11  bolt top-left row for fireReq.
- hitReq  in  1  collision on the pixel currently flagged by btiReq.
- clearAll  in  1  synchronous wipe (new level or game over).
- btiReq  out  1  bolt pixel present (registered).
- btiRGB  out  8  bolt colour; 8'h00 when btiReq=0.
- fireAck  out  1  one-cycle pulse: the previous-cycle fireReq was accepted.
- activeCount  out  4  number of valid slots.

## Operation
- Per slot: valid bit, x[10:0], y[10:0]. Shared cooldown counter, 6 bits, saturating at 0.
- Fire: fireReq is accepted when cooldown==0 and at least one slot is free at the start of the cycle.
  - The lowest-index free slot gets valid=1, x=fireX, y=fireY.
  - cooldown loads COOLDOWN and fireAck pulses.
  - Otherwise the request is dropped silently and fireAck stays 0. Requests are not queued.
- Move: on startOfFrame, every valid slot does y <= y+SPEED. The sum is computed in 12 bits with no wrap.
  - If the sum exceeds SCREEN_BOTTOM, the slot goes invalid.
  - cooldown decrements if nonzero.
- Draw: a slot covers a pixel when it is valid, x <= pixelX < x+BOLT_W, and y <= pixelY < y+BOLT_H, with 12-bit compares.
  - If several slots cover the pixel, the lowest index wins.
  - btiReq and drawIdx register the result each cycle.
- Hit: hitReq with btiReq=1 invalidates slot drawIdx at the next edge. hitReq with btiReq=0 is ignored.
- clearAll: invalidates all slots and zeroes cooldown. It beats fire, hit and move in the same cycle.
- Simultaneous events in one cycle:
  - Move and fire: existing slots move; the new bolt is written at fireY unmoved.
  - Move and hit on the same slot: the slot is invalidated, with no move.
  - Fire and hit: a slot freed by the hit is not allocatable in that cycle. A fire into a different free slot proceeds.
  - Fire, startOfFrame and cooldown==1 together: the fire is rejected, because cooldown is checked before the decrement.
- activeCount is the registered popcount of the valid bits and reflects slot state after each edge.

## Timing
- Reset: all slots invalid, cooldown=0; btiReq=0, btiRGB=8'h00, fireAck=0, activeCount=0.
- Draw latency is 1 cycle from pixelX/pixelY to btiReq/btiRGB. The mux adds its own register stage after this.
- fireAck is high exactly in the cycle after an accepted fireReq. The slot and activeCount update on the same edge.
- A hit clears the slot at the edge after hitReq. Pixels already in the pipeline may still draw once.
- Moves occur only on the edge that samples startOfFrame; there is no mid-frame motion.
- Reset asserted mid-operation returns everything immediately to the reset values.

## Test plan
- Fire at (100,50) after reset -> fireAck next cycle and activeCount=1. Pixel (100,50) gives btiReq=1, btiRGB=8'hFC one cycle later. Pixels (104,50) and (100,62) give btiReq=0.
- Two fireReqs with 31 frames between them -> second dropped, fireAck=0. A third after 32 frames -> accepted into slot 1.
- Five accepted-timing shots with BOLT_MAX=4 -> activeCount saturates at 4, fifth fireAck=0.
- Bolt fired at y=470 with SPEED=4 -> y=474 after frame 1, then 478. At frame 3 (482>479) -> invalid, activeCount decrements.
- hitReq while btiReq=1 on slot 2 -> slot 2 invalid next edge, slots 0/1/3 unaffected. hitReq with btiReq=0 -> no change.
- startOfFrame+fireReq in the same cycle with existing bolt at y=100 -> old bolt y=104, new bolt at fireY. clearAll in the same cycle -> all invalid, fireAck=0.

Source files
------------

// File: rtl/invader_bolts.sv
// Pool of invader bolts: allocates fire requests to free slots, moves them down
// each frame, retires them at the screen bottom or on hit, and draws them per pixel.
module invader_bolts #(
  parameter int          BOLT_MAX      = 4,
  parameter int          BOLT_W        = 4,
  parameter int          BOLT_H        = 12,
  parameter int          SPEED         = 4,
  parameter int          SCREEN_BOTTOM = 479,
  parameter int          COOLDOWN      = 32,
  parameter logic [7:0]  BOLT_COLOR    = 8'hFC
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        fireReq,
  input  logic [10:0] fireX,
  input  logic [10:0] fireY,
  input  logic        hitReq,
  input  logic        clearAll,
  output logic        btiReq,
  output logic [7:0]  btiRGB,
  output logic        fireAck,
  output logic [3:0]  activeCount
);

  localparam int IDX_W = (BOLT_MAX > 1) ? $clog2(BOLT_MAX) : 1;

  logic [BOLT_MAX-1:0] valid_vec;
  logic [BOLT_MAX-1:0] valid_next_vec;
  logic [BOLT_MAX-1:0] cover_vec;

  logic [5:0]       cooldown_reg, cooldown_next;
  logic             bti_req_reg;
  logic [7:0]       bti_rgb_reg;
  logic [IDX_W-1:0] draw_idx_reg;
  logic             fire_ack_reg;
  logic [3:0]       active_count_reg, active_count_next;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             draw_found;
  logic [IDX_W-1:0] draw_idx_next;
  logic             fire_ok;
  logic             hit_ok;

  // Free-slot and cover searches scan downward so the lowest index wins.
  always_comb begin
    free_found    = 1'b0;
    free_idx      = '0;
    draw_found    = 1'b0;
    draw_idx_next = '0;
    for (int i = BOLT_MAX - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (cover_vec[i]) begin
        draw_found    = 1'b1;
        draw_idx_next = IDX_W'(i);
      end
    end
  end

  // Cooldown is tested before any same-cycle frame decrement.
  assign fire_ok = fireReq && (cooldown_reg == 6'd0) && free_found && !clearAll;
  assign hit_ok  = hitReq && bti_req_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BOLT_MAX; gi++) begin : g_slot
      logic        v_reg, v_next;
      logic [10:0] x_reg, x_next;
      logic [10:0] y_reg, y_next;
      logic [11:0] y_sum;

      assign y_sum = {1'b0, y_reg} + 12'(SPEED);

      assign cover_vec[gi] = v_reg
        && ({1'b0, pixelX} >= {1'b0, x_reg})
        && ({1'b0, pixelX} <  ({1'b0, x_reg} + 12'(BOLT_W)))
        && ({1'b0, pixelY} >= {1'b0, y_reg})
        && ({1'b0, pixelY} <  ({1'b0, y_reg} + 12'(BOLT_H)));

      // Priority: wipe, allocate, hit, then per-frame move.
      always_comb begin
        v_next = v_reg;
        x_next = x_reg;
        y_next = y_reg;
        if (clearAll) begin
          v_next = 1'b0;
        end else if (fire_ok && (free_idx == IDX_W'(gi))) begin
          v_next = 1'b1;
          x_next = fireX;
          y_next = fireY;
        end else if (hit_ok && (draw_idx_reg == IDX_W'(gi))) begin
          v_next = 1'b0;
        end else if (startOfFrame && v_reg) begin
          if (y_sum > 12'(SCREEN_BOTTOM)) begin
            v_next = 1'b0;
          end else begin
            y_next = y_sum[10:0];
          end
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          v_reg <= 1'b0;
          x_reg <= '0;
          y_reg <= '0;
        end else begin
          v_reg <= v_next;
          x_reg <= x_next;
          y_reg <= y_next;
        end
      end

      assign valid_vec[gi]      = v_reg;
      assign valid_next_vec[gi] = v_next;
    end
  endgenerate

  always_comb begin
    cooldown_next = cooldown_reg;
    if (clearAll) begin
      cooldown_next = 6'd0;
    end else if (fire_ok) begin
      cooldown_next = 6'(COOLDOWN);
    end else if (startOfFrame && (cooldown_reg != 6'd0)) begin
      cooldown_next = cooldown_reg - 6'd1;
    end
  end

  always_comb begin
    active_count_next = 4'd0;
    for (int i = 0; i < BOLT_MAX; i++) begin
      active_count_next = active_count_next + 4'(valid_next_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown_reg     <= 6'd0;
      bti_req_reg      <= 1'b0;
      bti_rgb_reg      <= 8'h00;
      draw_idx_reg     <= '0;
      fire_ack_reg     <= 1'b0;
      active_count_reg <= 4'd0;
    end else begin
      cooldown_reg     <= cooldown_next;
      bti_req_reg      <= draw_found;
      bti_rgb_reg      <= draw_found ? BOLT_COLOR : 8'h00;
      draw_idx_reg     <= draw_idx_next;
      fire_ack_reg     <= fire_ok;
      active_count_reg <= active_count_next;
    end
  end

  assign btiReq      = bti_req_reg;
  assign btiRGB      = bti_rgb_reg;
  assign fireAck     = fire_ack_reg;
  assign activeCount = active_count_reg;

endmodule

// File: tb/tb_invader_bolts.sv
// Directed bench for invader_bolts; a second instance with a short cooldown
// exercises the full-pool case that bolt travel makes unreachable at the default.
`timescale 1ns/1ps
module tb_invader_bolts;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        fireReq;
  logic [10:0] fireX, fireY;
  logic        hitReq;
  logic        clearAll;

  logic        btiReq, fast_req;
  logic [7:0]  btiRGB, fast_rgb;
  logic        fireAck, fast_ack;
  logic [3:0]  activeCount, fast_count;

  int checks = 0;
  int errors = 0;
  logic       p_req;
  logic [7:0] p_rgb;

  always #5 clk = ~clk;

  invader_bolts dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .fireReq(fireReq),
    .fireX(fireX), .fireY(fireY), .hitReq(hitReq), .clearAll(clearAll),
    .btiReq(btiReq), .btiRGB(btiRGB), .fireAck(fireAck), .activeCount(activeCount)
  );

  invader_bolts #(.COOLDOWN(2)) dut_fast (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .fireReq(fireReq),
    .fireX(fireX), .fireY(fireY), .hitReq(hitReq), .clearAll(clearAll),
    .btiReq(fast_req), .btiRGB(fast_rgb), .fireAck(fast_ack), .activeCount(fast_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    pixelX = 11'd2047;
    pixelY = 11'd2047;
  endtask

  task automatic fire(input logic [10:0] x, input logic [10:0] y);
    fireReq = 1'b1; fireX = x; fireY = y;
    step();
    fireReq = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic clear_pool();
    clearAll = 1'b1;
    step();
    clearAll = 1'b0;
  endtask

  task automatic probe(input logic [10:0] x, input logic [10:0] y);
    pixelX = x; pixelY = y;
    step();
    p_req = btiReq;
    p_rgb = btiRGB;
    park();
    $display("probe (%0d,%0d): btiReq=%0b btiRGB=%02h", x, y, p_req, p_rgb);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    startOfFrame = 0; fireReq = 0; fireX = 0; fireY = 0;
    hitReq = 0; clearAll = 0; park();
    step(); step();
    checks++; if (btiReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", btiReq); end
    checks++; if (btiRGB !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %02h expected 00", btiRGB); end
    checks++; if (fireAck !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", fireAck); end
    checks++; if (activeCount !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", activeCount); end
    resetN = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_fire_draw();
    fire(11'd100, 11'd50);
    checks++; if (fireAck !== 1'b1) begin errors++; $display("FAIL fire_ack: got %0b expected 1", fireAck); end
    checks++; if (activeCount !== 4'd1) begin errors++; $display("FAIL fire_count: got %0d expected 1", activeCount); end
    step();
    checks++; if (fireAck !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %0b expected 0", fireAck); end
    probe(11'd100, 11'd50);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL draw_tl_req: got %0b expected 1", p_req); end
    checks++; if (p_rgb !== 8'hFC) begin errors++; $display("FAIL draw_tl_rgb: got %02h expected fc", p_rgb); end
    probe(11'd103, 11'd61);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL draw_br_req: got %0b expected 1", p_req); end
    probe(11'd104, 11'd50);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL draw_right_req: got %0b expected 0", p_req); end
    checks++; if (p_rgb !== 8'h00) begin errors++; $display("FAIL draw_right_rgb: got %02h expected 00", p_rgb); end
    probe(11'd100, 11'd62);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL draw_below_req: got %0b expected 0", p_req); end
    probe(11'd99, 11'd50);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL draw_left_req: got %0b expected 0", p_req); end
    $display("test_fire_draw done");
  endtask

  task automatic test_cooldown();
    clear_pool();
    checks++; if (activeCount !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", activeCount); end
    fire(11'd10, 11'd10);
    checks++; if (fireAck !== 1'b1) begin errors++; $display("FAIL cd_first_ack: got %0b expected 1", fireAck); end
    frames(31);
    fire(11'd20, 11'd10);
    checks++; if (fireAck !== 1'b0) begin errors++; $display("FAIL cd_early_ack: got %0b expected 0", fireAck); end
    checks++; if (activeCount !== 4'd1) begin errors++; $display("FAIL cd_early_count: got %0d expected 1", activeCount); end
    frames(1);
    fire(11'd30, 11'd10);
    checks++; if (fireAck !== 1'b1) begin errors++; $display("FAIL cd_late_ack: got %0b expected 1", fireAck); end
    checks++; if (activeCount !== 4'd2) begin errors++; $display("FAIL cd_late_count: got %0d expected 2", activeCount); end
    probe(11'd30, 11'd10);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL cd_new_draw: got %0b expected 1", p_req); end
    $display("test_cooldown done");
  endtask

  task automatic test_full();
    clear_pool();
    for (int k = 0; k < 4; k++) begin
      fire(11'(k * 10), 11'd0);
      checks++; if (fast_ack !== 1'b1) begin errors++; $display("FAIL full_ack%0d: got %0b expected 1", k, fast_ack); end
      checks++; if (fast_count !== 4'(k + 1)) begin errors++; $display("FAIL full_count%0d: got %0d expected %0d", k, fast_count, k + 1); end
      frames(2);
    end
    fire(11'd200, 11'd0);
    checks++; if (fast_ack !== 1'b0) begin errors++; $display("FAIL full_fifth_ack: got %0b expected 0", fast_ack); end
    checks++; if (fast_count !== 4'd4) begin errors++; $display("FAIL full_fifth_count: got %0d expected 4", fast_count); end
    $display("test_full done");
  endtask

  task automatic test_bottom();
    clear_pool();
    fire(11'd200, 11'd470);
    frames(1);
    probe(11'd200, 11'd474);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL bot_474: got %0b expected 1", p_req); end
    probe(11'd200, 11'd473);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL bot_473: got %0b expected 0", p_req); end
    frames(1);
    probe(11'd200, 11'd478);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL bot_478: got %0b expected 1", p_req); end
    probe(11'd200, 11'd477);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL bot_477: got %0b expected 0", p_req); end
    checks++; if (activeCount !== 4'd1) begin errors++; $display("FAIL bot_count_live: got %0d expected 1", activeCount); end
    frames(1);
    checks++; if (activeCount !== 4'd0) begin errors++; $display("FAIL bot_count_gone: got %0d expected 0", activeCount); end
    probe(11'd200, 11'd479);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL bot_gone_draw: got %0b expected 0", p_req); end
    $display("test_bottom done");
  endtask

  task automatic test_hit();
    clear_pool();
    // Slots end at y = 384, 256, 128, 0 after three cooldown periods.
    for (int k = 0; k < 4; k++) begin
      fire(11'(10 + 20 * k), 11'd0);
      if (k < 3) frames(32);
    end
    checks++; if (activeCount !== 4'd4) begin errors++; $display("FAIL hit_setup_count: got %0d expected 4", activeCount); end
    pixelX = 11'd50; pixelY = 11'd128;
    step();
    checks++; if (btiReq !== 1'b1) begin errors++; $display("FAIL hit_target_req: got %0b expected 1", btiReq); end
    hitReq = 1'b1;
    step();
    hitReq = 1'b0;
    park();
    checks++; if (activeCount !== 4'd3) begin errors++; $display("FAIL hit_count: got %0d expected 3", activeCount); end
    probe(11'd50, 11'd128);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL hit_slot2: got %0b expected 0", p_req); end
    probe(11'd10, 11'd384);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL hit_slot0: got %0b expected 1", p_req); end
    probe(11'd30, 11'd256);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL hit_slot1: got %0b expected 1", p_req); end
    probe(11'd70, 11'd0);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL hit_slot3: got %0b expected 1", p_req); end
    step();
    hitReq = 1'b1;
    step();
    hitReq = 1'b0;
    checks++; if (activeCount !== 4'd3) begin errors++; $display("FAIL hit_idle_count: got %0d expected 3", activeCount); end
    $display("test_hit done");
  endtask

  task automatic test_simultaneous();
    clear_pool();
    fire(11'd300, 11'd0);
    frames(32);
    // Frame and fire together: old bolt 128 -> 132, new bolt stays at fireY.
    startOfFrame = 1'b1;
    fire(11'd400, 11'd60);
    startOfFrame = 1'b0;
    checks++; if (fireAck !== 1'b1) begin errors++; $display("FAIL sim_ack: got %0b expected 1", fireAck); end
    checks++; if (activeCount !== 4'd2) begin errors++; $display("FAIL sim_count: got %0d expected 2", activeCount); end
    probe(11'd300, 11'd132);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL sim_old_moved: got %0b expected 1", p_req); end
    probe(11'd300, 11'd131);
    checks++; if (p_req !== 1'b0) begin errors++; $display("FAIL sim_old_top: got %0b expected 0", p_req); end
    probe(11'd400, 11'd60);
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL sim_new_unmoved: got %0b expected 1", p_req); end
    frames(31);
    startOfFrame = 1'b1;
    fire(11'd500, 11'd0);
    startOfFrame = 1'b0;
    checks++; if (fireAck !== 1'b0) begin errors++; $display("FAIL sim_cd1_ack: got %0b expected 0", fireAck); end
    checks++; if (activeCount !== 4'd2) begin errors++; $display("FAIL sim_cd1_count: got %0d expected 2", activeCount); end
    startOfFrame = 1'b1;
    clearAll = 1'b1;
    fire(11'd500, 11'd0);
    startOfFrame = 1'b0;
    clearAll = 1'b0;
    checks++; if (fireAck !== 1'b0) begin errors++; $display("FAIL sim_clear_ack: got %0b expected 0", fireAck); end
    checks++; if (activeCount !== 4'd0) begin errors++; $display("FAIL sim_clear_count: got %0d expected 0", activeCount); end
    fire(11'd500, 11'd0);
    checks++; if (fireAck !== 1'b1) begin errors++; $display("FAIL sim_after_clear_ack: got %0b expected 1", fireAck); end
    $display("test_simultaneous done");
  endtask

  task automatic test_midreset();
    checks++; if (activeCount !== 4'd1) begin errors++; $display("FAIL mid_pre_count: got %0d expected 1", activeCount); end
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (activeCount !== 4'd0) begin errors++; $display("FAIL mid_async_count: got %0d expected 0", activeCount); end
    step();
    resetN = 1'b1;
    fire(11'd20, 11'd20);
    checks++; if (fireAck !== 1'b1) begin errors++; $display("FAIL mid_cd_zero_ack: got %0b expected 1", fireAck); end
    $display("test_midreset done");
  endtask

  initial begin
    test_reset();
    test_fire_draw();
    test_cooldown();
    test_full();
    test_bottom();
    test_hit();
    test_simultaneous();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
